// File: rtl/histogram_pkg.sv
// Shared constants, lane layout and FSM encoding for the histogram readout path.
// Bin offset 0 lives in the most significant lane of a scratch word.
package histogram_pkg;

    localparam int NUM_BINS      = 256;
    localparam int BINS_PER_WORD = 4;
    localparam int BIN_W         = 32;
    localparam int SCRATCH_WORDS = NUM_BINS / BINS_PER_WORD;

    localparam int LANE0_LSB = 96;
    localparam int LANE1_LSB = 64;
    localparam int LANE2_LSB = 32;
    localparam int LANE3_LSB = 0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int lane_lsb(input int lane, input int bin_w);
        return (BINS_PER_WORD - 1 - lane) * bin_w;
    endfunction

endpackage

// File: rtl/histogram_cdf_reader_if.sv
// Control, scratch-read and output-write signals of the CDF readout engine.
// The master side is the reader; the slave side is the memories and controller.
interface histogram_cdf_reader_if #(
    parameter int NUM_WORDS = 64,
    parameter int BIN_W     = 32,
    parameter int ADDR_W    = 16
);
    localparam int WORD_W = 4 * BIN_W;

    logic                 start;
    logic [NUM_WORDS-1:0] scratch_written_mask;
    logic [ADDR_W-1:0]    scratch_memory_address_pointer;
    logic [WORD_W-1:0]    scratch_memory_rdata;
    logic                 output_memory_write_enable;
    logic [ADDR_W-1:0]    output_memory_address;
    logic [WORD_W-1:0]    output_memory_wdata;
    logic                 busy;
    logic                 done;
    logic [BIN_W-1:0]     total_count;

    modport master (
        input  start, scratch_written_mask, scratch_memory_rdata,
        output scratch_memory_address_pointer, output_memory_write_enable,
        output_memory_address, output_memory_wdata, busy, done, total_count
    );

    modport slave (
        output start, scratch_written_mask, scratch_memory_rdata,
        input  scratch_memory_address_pointer, output_memory_write_enable,
        output_memory_address, output_memory_wdata, busy, done, total_count
    );

endinterface

// File: rtl/histogram_prefix4.sv
// Combinational 4-lane prefix adder: adds one scratch word onto the running sum.
// A cleared mask bit zeroes every bin, so undefined scratch data never propagates.
module histogram_prefix4
    import histogram_pkg::*;
#(
    parameter int BIN_W = histogram_pkg::BIN_W
) (
    input  logic [BIN_W-1:0]               run_in,
    input  logic [BINS_PER_WORD*BIN_W-1:0] word,
    input  logic                           mask_bit,
    output logic [BINS_PER_WORD*BIN_W-1:0] cum_word,
    output logic [BIN_W-1:0]               run_out
);

    logic [BIN_W-1:0] bin;
    logic [BIN_W-1:0] acc;

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        cum_word = '0;
        bin      = '0;
        acc      = run_in;
        for (int lane = 0; lane < BINS_PER_WORD; lane++) begin
            bin = mask_bit ? word[lane_lsb(lane, BIN_W) +: BIN_W] : '0;
            acc = acc + bin;
            cum_word[lane_lsb(lane, BIN_W) +: BIN_W] = acc;
        end
        run_out = acc;
    end

endmodule

// File: rtl/histogram_cdf_reader.sv
// Reads back the scratch histogram, builds the running CDF and writes it out.
// Pipeline: registered read address, one-cycle read latency, registered write.
module histogram_cdf_reader
    import histogram_pkg::*;
#(
    parameter int                NUM_WORDS = SCRATCH_WORDS,
    parameter int                BIN_W     = histogram_pkg::BIN_W,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] OUT_BASE  = '0
) (
    input logic                    clock,
    input logic                    reset,
    histogram_cdf_reader_if.master bus
);

    localparam int                IDX_W     = $clog2(NUM_WORDS);
    localparam int                WORD_W    = BINS_PER_WORD * BIN_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t             state;
    logic [ADDR_W-1:0]  rd_addr;
    logic               drain_cnt;
    logic               b_valid;
    logic [ADDR_W-1:0]  b_idx;
    logic [BIN_W-1:0]   run;
    logic [BIN_W-1:0]   run_next;
    logic [WORD_W-1:0]  cum_word;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WORD_W-1:0]  wr_data;
    logic               done_q;
    logic [BIN_W-1:0]   total_q;

    // Stage B: mask for the word whose data is arriving now.
    histogram_prefix4 #(.BIN_W(BIN_W)) u_prefix (
        .run_in   (run),
        .word     (bus.scratch_memory_rdata),
        .mask_bit (bus.scratch_written_mask[b_idx[IDX_W-1:0]]),
        .cum_word (cum_word),
        .run_out  (run_next)
    );

    // NOTE: all state updates are non-blocking so each stage sees pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            b_valid   <= 1'b0;
            b_idx     <= '0;
            run       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done_q    <= 1'b0;
            total_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            b_valid <= (state == ST_READ);
            b_idx   <= rd_addr;
            wr_en   <= b_valid;
            if (b_valid) begin
                wr_addr <= OUT_BASE + b_idx;
                wr_data <= cum_word;
                run     <= run_next;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        state   <= ST_READ;
                        rd_addr <= '0;
                        run     <= '0;
                    end
                end
                ST_READ: begin
                    if (rd_addr == LAST_ADDR) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt) begin
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        total_q <= run;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.scratch_memory_address_pointer = rd_addr;
    assign bus.output_memory_write_enable     = wr_en;
    assign bus.output_memory_address          = wr_addr;
    assign bus.output_memory_wdata            = wr_data;
    assign bus.busy                           = (state == ST_READ) || (state == ST_DRAIN);
    assign bus.done                           = done_q;
    assign bus.total_count                    = total_q;

endmodule

// File: tb/tb_histogram_cdf_reader.sv
// Self-checking bench for histogram_cdf_reader: directed scenarios plus random runs,
// compared against a plain-arithmetic cumulative-sum model of the scratch contents.
module tb_histogram_cdf_reader;

    localparam int          NW       = 64;
    localparam logic [15:0] OUT_BASE = 16'hFFE0;
    localparam int          LOG_N    = 4096;

    typedef struct {
        int           c;
        logic [15:0]  a;
        logic [127:0] d;
    } wr_rec_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [NW-1:0] mask  = '0;
    logic [127:0]  rdata = '0;
    logic [127:0]  scratch_mem [NW];

    logic [127:0]  exp_words [NW];
    logic [31:0]   exp_total;

    int            cyc = 0;
    logic          busy_log  [LOG_N];
    logic          done_log  [LOG_N];
    logic [31:0]   total_log [LOG_N];
    wr_rec_t       wr_q [$];

    int            tests = 0;
    int            fails = 0;

    always #5 clock = ~clock;

    histogram_cdf_reader_if #(.NUM_WORDS(NW), .BIN_W(32), .ADDR_W(16)) bus ();

    histogram_cdf_reader #(
        .NUM_WORDS (NW),
        .BIN_W     (32),
        .ADDR_W    (16),
        .OUT_BASE  (OUT_BASE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.start                = start;
    assign bus.scratch_written_mask = mask;
    assign bus.scratch_memory_rdata = rdata;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rdata <= scratch_mem[bus.scratch_memory_address_pointer[5:0]];
    end

    always @(negedge clock) begin
        if (cyc < LOG_N) begin
            busy_log[cyc]  = bus.busy;
            done_log[cyc]  = bus.done;
            total_log[cyc] = bus.total_count;
        end
        if (bus.output_memory_write_enable === 1'b1)
            wr_q.push_back('{cyc, bus.output_memory_address, bus.output_memory_wdata});
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: bins read left-to-right per word, masked words count as zero.
    task automatic compute_expected();
        logic [31:0] sum;
        logic [31:0] b;
        sum = 0;
        for (int k = 0; k < NW; k++) begin
            for (int lane = 0; lane < 4; lane++) begin
                b = mask[k] ? scratch_mem[k][127 - 32*lane -: 32] : 32'd0;
                sum = sum + b;
                exp_words[k][127 - 32*lane -: 32] = sum;
            end
        end
        exp_total = sum;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic pulse_start(output int s);
        @(negedge clock);
        start = 1'b1;
        s = cyc + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Relative cycle r of a run started at s lives at absolute cycle s + r - 1.
    task automatic check_run(input string tag, input int s);
        int n;
        int rel;
        int nbusy;
        int ndone;
        n = 0;
        foreach (wr_q[i]) begin
            rel = wr_q[i].c - s + 1;
            if (rel >= 1 && rel <= 67) begin
                if (n < NW) begin
                    check($sformatf("%s w%0d cycle", tag, n), 128'(rel), 128'(n + 3));
                    check($sformatf("%s w%0d addr", tag, n), 128'(wr_q[i].a), 128'(16'(OUT_BASE + n)));
                    check($sformatf("%s w%0d data", tag, n), wr_q[i].d, exp_words[n]);
                end
                n++;
            end
        end
        check({tag, " write count"}, 128'(n), 128'(NW));
        nbusy = 0;
        ndone = 0;
        for (int r = 1; r <= 67; r++) begin
            if (busy_log[s + r - 1] === 1'b1) nbusy++;
            if (done_log[s + r - 1] === 1'b1) ndone++;
        end
        check({tag, " busy before"}, 128'(busy_log[s - 1]), 128'(1'b0));
        check({tag, " busy first"}, 128'(busy_log[s]), 128'(1'b1));
        check({tag, " busy last"}, 128'(busy_log[s + 65]), 128'(1'b1));
        check({tag, " busy cycles"}, 128'(nbusy), 128'(66));
        check({tag, " busy at done"}, 128'(busy_log[s + 66]), 128'(1'b0));
        check({tag, " done early"}, 128'(done_log[s + 65]), 128'(1'b0));
        check({tag, " done pulse"}, 128'(done_log[s + 66]), 128'(1'b1));
        check({tag, " done after"}, 128'(done_log[s + 67]), 128'(1'b0));
        check({tag, " done count"}, 128'(ndone), 128'(1));
        check({tag, " total"}, 128'(total_log[s + 66]), 128'(exp_total));
    endtask

    task automatic fill_all(input logic [127:0] v);
        for (int k = 0; k < NW; k++) scratch_mem[k] = v;
    endtask

    initial begin
        int s;
        int s2;

        fill_all('1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset busy", 128'(bus.busy), 128'(1'b0));
        check("reset done", 128'(bus.done), 128'(1'b0));
        check("reset we", 128'(bus.output_memory_write_enable), 128'(1'b0));
        check("reset total", 128'(bus.total_count), 128'(0));
        check("reset raddr", 128'(bus.scratch_memory_address_pointer), 128'(0));
        check("reset waddr", 128'(bus.output_memory_address), 128'(0));
        check("reset wdata", bus.output_memory_wdata, 128'(0));

        // Empty mask over all-ones data.
        mask = '0;
        compute_expected();
        pulse_start(s);
        wait_until(s + 69);
        check_run("t1", s);

        // Only word 5 valid.
        fill_all('1);
        scratch_mem[5] = {32'd1, 32'd2, 32'd3, 32'd4};
        mask = 64'd1 << 5;
        compute_expected();
        pulse_start(s);
        wait_until(s + 69);
        check_run("t2", s);

        // Every bin holds one.
        fill_all({32'd1, 32'd1, 32'd1, 32'd1});
        mask = '1;
        compute_expected();
        pulse_start(s);
        wait_until(s + 69);
        check_run("t3", s);

        // Extra start during READ is ignored.
        pulse_start(s);
        wait_until(s + 19);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_until(s + 69);
        check_run("t4", s);

        // Reset in the middle of a run, then a clean rerun.
        pulse_start(s);
        wait_until(s + 29);
        reset = 1'b1;
        @(negedge clock);
        check("t5 we after reset", 128'(bus.output_memory_write_enable), 128'(1'b0));
        check("t5 busy after reset", 128'(bus.busy), 128'(1'b0));
        check("t5 done after reset", 128'(bus.done), 128'(1'b0));
        check("t5 total after reset", 128'(bus.total_count), 128'(0));
        reset = 1'b0;
        pulse_start(s);
        wait_until(s + 69);
        check_run("t5", s);

        // Start coincident with the done pulse chains straight into a new run.
        pulse_start(s);
        wait_until(s + 66);
        check("t6 done at chain", 128'(bus.done), 128'(1'b1));
        start = 1'b1;
        s2 = cyc + 1;
        @(negedge clock);
        start = 1'b0;
        wait_until(s2 + 69);
        check_run("t6a", s);
        check_run("t6b", s2);

        // Random data and masks; unwritten words carry undefined data.
        for (int t = 0; t < 2; t++) begin
            mask = {$urandom, $urandom};
            for (int k = 0; k < NW; k++) begin
                if (mask[k])
                    scratch_mem[k] = {$urandom, $urandom, $urandom, $urandom};
                else
                    scratch_mem[k] = 'x;
            end
            compute_expected();
            pulse_start(s);
            wait_until(s + 69);
            check_run($sformatf("rnd%0d", t), s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/histogram_cdf_reader.md
Name: histogram_cdf_reader

Overview:
Readout engine for the histogram block. After the histogram data path has finished its read-modify-write of 256 bins into scratch memory, this block reads them back.
- Scratch memory: 64 words x 4 bins x 32 bit.
- Words never written are forced to zero, using the per-word written mask.
- It computes the running cumulative sum (CDF) and writes it, in the same packing, to an output memory for the equalisation stage.

Parameters:
NUM_WORDS, 64, scratch words holding bins (4 bins per word)
BIN_W, 32, width of one bin / cumulative count
ADDR_W, 16, memory address width
OUT_BASE, 16'd0, first output-memory word address

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin readout (ignored unless IDLE or DONE)
scratch_written_mask  input  64  bit k=1 means scratch word k holds valid data
scratch_memory_address_pointer  output  ADDR_W  scratch read address
scratch_memory_rdata  input  128  scratch read data, valid one cycle after address
output_memory_write_enable  output  1  output-memory write strobe
output_memory_address  output  ADDR_W  output write address
output_memory_wdata  output  128  four packed cumulative counts
busy  output  1  readout in progress
done  output  1  one-cycle pulse after last write
total_count  output  BIN_W  final cumulative sum; held until next start

Behaviour:
- Reset values: all outputs 0; state IDLE; running sum 0.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE/DONE + start -> READ; read index k=0, running sum cleared.
  - READ: drive scratch address k each cycle, k++. After issuing k=NUM_WORDS-1 -> DRAIN.
  - DRAIN: two cycles, flushing the read-latency stage and the write stage -> DONE.
  - DONE: pulse done for one cycle; stay in DONE until start; busy=0.
- Pipeline:
  - Stage A: address k registered.
  - Stage B: rdata for k arrives, word index k delayed by one cycle.
  - Stage C: registered write.
- Timing: start sampled at edge E0 -> address 0 visible cycle 1 -> write of word 0 visible cycle 3. Word 63 is written in cycle 66, done pulses in cycle 67. busy is high in cycles 1..66.
- Lane order matches the writer: bin offset 0 in [127:96], 1 in [95:64], 2 in [63:32], 3 in [31:0].
- Per word k, b0..b3 are the four bins; each bin is forced to 0 if scratch_written_mask[k]==0, regardless of rdata (including X).
- Prefix sums:
  - c0 = run + b0; c1 = c0 + b1; c2 = c1 + b2; c3 = c2 + b3.
  - wdata = {c0,c1,c2,c3}; run <= c3.
- Arithmetic is mod 2^BIN_W; wrap is not flagged.
- output_memory_address = OUT_BASE + k (ADDR_W bits, wraps).
- write_enable is high for exactly NUM_WORDS cycles, consecutive, with no gaps.
- total_count is updated with the final c3 in the cycle done pulses.
- scratch_written_mask is sampled in stage B, per word; it must be stable during busy.
- start while READ/DRAIN is ignored; no restart and no error.
- start in the same cycle as the done pulse is accepted: READ begins next cycle.
- Reset mid-operation: next cycle write_enable=0, busy=0, state IDLE. No partial done; total_count=0.
- Scratch address holds its last value outside READ.

Decomposition:
- Shared package histogram_pkg:
  - NUM_BINS=256, BINS_PER_WORD=4, BIN_W=32, SCRATCH_WORDS=64
  - lane bit-slice constants
  - FSM state enum
- One natural sub-module: histogram_prefix4, combinational 4-lane prefix adder (run_in, 128-bit word, mask bit -> 128-bit cumulative word, run_out).

Test Plan:
1. mask=0, rdata=all ones, start -> 64 writes of 0 at addresses OUT_BASE..OUT_BASE+63; total_count=0; done in cycle 67.
2. mask bit 5 only, word5 data {1,2,3,4} -> words 0-4 written 0; word5 {1,3,6,10}; words 6-63 {10,10,10,10}; total_count=10.
3. All mask set, every bin=1 -> word k = {4k+1,4k+2,4k+3,4k+4}; word 63 = {253,254,255,256}; total_count=256.
4. start pulsed again at cycle 20 -> ignored; exactly 64 writes; single done pulse.
5. reset asserted at cycle 30 -> cycle 31 write_enable=0, busy=0; a new start gives a correct full result identical to scenario 3.
6. start coincident with done -> second run begins immediately; running sum restarts at 0; identical write stream.
